// File: rtl/e_mdu_if.sv
// rtl/e_mdu_if.sv - E-stage to multiply/divide unit signal bundle
interface e_mdu_if;
  logic [31:0] E_rs_data;
  logic [31:0] E_rt_data;
  logic [3:0]  E_MDUop;
  logic        E_start;
  logic        E_flush;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] E_MDUout;

  modport master (
    output E_rs_data, E_rt_data, E_MDUop, E_start, E_flush,
    input  busy, HI, LO, E_MDUout
  );

  modport slave (
    input  E_rs_data, E_rt_data, E_MDUop, E_start, E_flush,
    output busy, HI, LO, E_MDUout
  );
endinterface

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multiply/divide unit with HI/LO registers
// Result is computed at start and held pending until the fixed busy window ends.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic   clk,
  input  logic   reset,
  e_mdu_if.slave bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [0:0]  r_state;
  logic [15:0] r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_pend_we;

  logic        w_start;
  logic        w_mt_ok;
  logic        w_is_mul;
  logic        w_is_sdiv;
  logic [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_div_b;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_start   = (r_state == S_IDLE) && bus.E_start && !bus.E_flush &&
                     (bus.E_MDUop >= OP_MULT) && (bus.E_MDUop <= OP_DIVU);
  assign w_mt_ok   = (r_state == S_IDLE) && !bus.E_start && !bus.E_flush;
  assign w_is_mul  = (bus.E_MDUop == OP_MULT) || (bus.E_MDUop == OP_MULTU);
  assign w_is_sdiv = (bus.E_MDUop == OP_DIV);

  assign w_sprod = $signed({{32{bus.E_rs_data[31]}}, bus.E_rs_data}) *
                   $signed({{32{bus.E_rt_data[31]}}, bus.E_rt_data});
  assign w_uprod = {32'd0, bus.E_rs_data} * {32'd0, bus.E_rt_data};

  // Signed divide on magnitudes so MIN / -1 wraps to MIN instead of trapping.
  assign w_abs_a = (w_is_sdiv && bus.E_rs_data[31]) ? -bus.E_rs_data : bus.E_rs_data;
  assign w_abs_b = (w_is_sdiv && bus.E_rt_data[31]) ? -bus.E_rt_data : bus.E_rt_data;
  assign w_div_b = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;
  assign w_q     = w_abs_a / w_div_b;
  assign w_r     = w_abs_a % w_div_b;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (bus.E_MDUop)
      OP_MULT:  begin w_res_hi = w_sprod[63:32]; w_res_lo = w_sprod[31:0]; end
      OP_MULTU: begin w_res_hi = w_uprod[63:32]; w_res_lo = w_uprod[31:0]; end
      OP_DIV: begin
        w_res_lo = (bus.E_rs_data[31] ^ bus.E_rt_data[31]) ? -w_q : w_q;
        w_res_hi = bus.E_rs_data[31] ? -w_r : w_r;
      end
      OP_DIVU:  begin w_res_hi = w_r; w_res_lo = w_q; end
      default:  begin w_res_hi = 32'd0; w_res_lo = 32'd0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 16'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_we <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_start) begin
        r_state   <= S_RUN;
        r_cnt     <= w_is_mul ? 16'(MULT_CYCLES) : 16'(DIV_CYCLES);
        r_pend_hi <= w_res_hi;
        r_pend_lo <= w_res_lo;
        r_pend_we <= w_is_mul || (bus.E_rt_data != 32'd0);
      end else if (w_mt_ok && bus.E_MDUop == OP_MTHI) begin
        r_hi <= bus.E_rs_data;
      end else if (w_mt_ok && bus.E_MDUop == OP_MTLO) begin
        r_lo <= bus.E_rs_data;
      end
    end else begin
      r_cnt <= r_cnt - 16'd1;
      if (r_cnt == 16'd1) begin
        r_state <= S_IDLE;
        if (r_pend_we) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end
    end
  end

  assign bus.busy     = (r_state == S_RUN);
  assign bus.HI       = r_hi;
  assign bus.LO       = r_lo;
  assign bus.E_MDUout = (bus.E_MDUop == OP_MFHI) ? r_hi :
                        (bus.E_MDUop == OP_MFLO) ? r_lo : 32'd0;
endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
Multiply/divide unit in the E stage of the 5-stage MIPS pipeline. It sits directly downstream of the E-stage rs/rt forwarding muxes and takes their already-forwarded operands. It executes mult/multu/div/divu over a fixed multi-cycle latency and holds the HI/LO registers. It serves mfhi/mflo/mthi/mtlo, and exports start/busy so the D-stage stall logic can hold MDU-class instructions.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (sampled on rising clk edge; 0 = reset)
E_rs_data  input  32  forwarded rs operand (after rs forwarding mux)
E_rt_data  input  32  forwarded rt operand (after rt forwarding mux)
E_MDUop  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none
E_start  input  1  single-cycle pulse, asserted with E_MDUop 1-4
E_flush  input  1  E-stage instruction is a bubble/cancelled; suppresses start and mthi/mtlo this cycle
busy  output  1  multi-cycle operation in progress
HI  output  32  architectural HI
LO  output  32  architectural LO
E_MDUout  output  32  mfhi -> HI, mflo -> LO, otherwise 0 (combinational)

Behaviour:
- Reset (reset==0 at an edge): HI=0, LO=0, busy=0, counter=0, pending result cleared. Takes priority over everything else. Reset mid-operation aborts the operation; no HI/LO update follows.
- States: IDLE (busy=0), RUN (busy=1).
- IDLE -> RUN: at the edge ending cycle T with E_start=1, E_flush=0 and E_MDUop in 1-4.
  - Operands are latched.
  - Result is computed into internal pend_hi/pend_lo.
  - Counter is loaded with MULT_CYCLES or DIV_CYCLES.
- RUN: counter decrements each edge. busy=1 in cycles T+1..T+N.
  - At the edge ending T+N (counter==1): HI<=pend_hi, LO<=pend_lo, busy<=0, return to IDLE.
  - New HI/LO are visible from cycle T+N+1.
- mult: signed 32x32 -> 64; HI = product[63:32], LO = product[31:0].
- multu: unsigned 32x32 -> 64; same split as mult.
- div: signed division, quotient truncated toward zero. LO = quotient; HI = remainder, sign of dividend.
- divu: unsigned division; LO = quotient, HI = remainder.
- Divisor 0 (div/divu): full DIV_CYCLES busy period still runs, then HI/LO are left unchanged (no write).
- div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wrap, no trap).
- mthi: HI <= E_rs_data at the edge, only when busy=0, E_flush=0 and E_start=0.
- mtlo: LO <= E_rs_data under the same conditions as mthi.
- mfhi/mflo: E_MDUout reads the current HI/LO register. Result is only architecturally valid while busy=0; the stall logic guarantees this.
- E_start while busy=1: ignored. In-flight operation and counter are unaffected (protocol violation, flagged by bench assertion).
- mthi/mtlo while busy=1: ignored.
- E_flush=1: E_start and mthi/mtlo are ignored that cycle. An already-running operation is NOT cancelled.
- D-stage stall contract: MDU-class instruction in D stalls while (E_start | busy).

Test Plan:
- Reset: hold reset=0 for 2 cycles -> HI=LO=0, busy=0, E_MDUout=0.
- mult: rs=0xFFFFFFFE (-2), rt=3, start at T -> busy=1 in T+1..T+5; HI=0xFFFFFFFF, LO=0xFFFFFFFA at T+6.
- multu: same operands -> HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
- div: rs=-7, rt=2 -> after 10 busy cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- Divide by zero: preload HI=0x11, LO=0x22 via mthi/mtlo, then divu by 0 -> busy for 10 cycles, HI=0x11, LO=0x22 unchanged.
- Corner cases:
  - mtlo 0x1234 issued during busy -> ignored.
  - Second E_start during busy -> ignored, first result lands on schedule.
  - reset=0 at busy cycle 3 -> busy=0, HI=LO=0 next cycle, no later update.
  - E_flush=1 with E_start -> busy stays 0.
